alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and flag bundle for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, DATA_WIDTH cycles.
// The final add is combinational so the product is ready in the cycle done_o is high.
module alu_mul_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o,
  output logic                  high_nz_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [2*DATA_WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]        count_q;

  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o    = (count_q == CNT_W'(1));
    product_o = acc_d[DATA_WIDTH-1:0];
    high_nz_o = |acc_d[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{DATA_WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      count_q  <= CNT_W'(DATA_WIDTH);
    end else if (count_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with registered result and flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 1100; otherwise it is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  Illegal
);

  localparam int MSB = DATA_WIDTH - 1;

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH:0]   sum_w, diff_w;
  logic                  add_ovf, sub_ovf, accept, is_mul, load_alu;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_res, result_q;
  alu_flags_t            alu_flags, flags_q;
  logic                  zero_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum_w     = {1'b0, A} + {1'b0, B};
    diff_w    = {1'b0, A} - {1'b0, B};
    add_ovf   = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
    sub_ovf   = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
    shamt     = B[SHAMT_W-1:0];
    alu_res   = '0;
    alu_flags = '0;
    case (ALUop)
      ALU_AND:  alu_res = A & B;
      ALU_OR:   alu_res = A | B;
      ALU_XOR:  alu_res = A ^ B;
      ALU_NOR:  alu_res = ~(A | B);
      ALU_ADD: begin
        alu_res            = sum_w[MSB:0];
        alu_flags.overflow = add_ovf;
        alu_flags.carry    = sum_w[DATA_WIDTH];
      end
      ALU_SUB: begin
        alu_res            = diff_w[MSB:0];
        alu_flags.overflow = sub_ovf;
        alu_flags.carry    = diff_w[DATA_WIDTH];
      end
      // Borrow out of A-B is the unsigned less-than; sign XOR overflow is the signed one.
      ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, diff_w[DATA_WIDTH]};
      ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, diff_w[MSB] ^ sub_ovf};
      ALU_SLL:  alu_res = A << shamt;
      ALU_SRL:  alu_res = A >> shamt;
      ALU_SRA:  alu_res = $signed(A) >>> shamt;
`ifdef ALU_MUL_EN
      ALU_MUL:  alu_res = '0;
`endif
      default:  alu_flags.illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                  mul_done, mul_high_nz;
  logic [DATA_WIDTH-1:0] mul_prod;

  assign is_mul = (ALUop == ALU_MUL);

  alu_mul_seq #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept && is_mul),
    .a_i       (A),
    .b_i       (B),
    .done_o    (mul_done),
    .product_o (mul_prod),
    .high_nz_o (mul_high_nz)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = is_mul ? ST_BUSY : ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) state_d = is_mul ? ST_BUSY : ST_DONE;
          else          state_d = ST_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      ST_BUSY: if (mul_done) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
    accept    = in_valid && in_ready;
    load_alu  = accept && !is_mul;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      zero_q   <= 1'b0;
    end else if (load_alu) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
      zero_q   <= (alu_res == '0);
    end
`ifdef ALU_MUL_EN
    else if ((state_q == ST_BUSY) && mul_done) begin
      result_q <= mul_prod;
      flags_q  <= '{overflow: mul_high_nz, carry: 1'b0, illegal: 1'b0};
      zero_q   <= (mul_prod == '0);
    end
`endif
  end

  assign Result   = result_q;
  assign Overflow = flags_q.overflow;
  assign CarryOut = flags_q.carry;
  assign Illegal  = flags_q.illegal;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (DATA_WIDTH=32): directed vector table, handshake
// sequences and randomized ops against an arithmetic reference model. Honors ALU_MUL_EN.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Result;
  logic [3:0]   ALUop;
  logic         Overflow, CarryOut, Zero, Illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .Zero      (Zero),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         cy;
    logic         zero;
    logic         ill;
  } exp_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         exp;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode semantics.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   r;
    longint sa, sb, s;
    logic [63:0] p;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r  = '0;
    case (op)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b0011: r.res = a ^ b;
      4'b0100: r.res = ~(a | b);
      4'b0010: begin
        r.res = a + b;
        s     = sa + sb;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        p     = 64'(a) + 64'(b);
        r.cy  = (p[63:32] != 0);
      end
      4'b0110: begin
        r.res = a - b;
        s     = sa - sb;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.cy  = (a < b);
      end
      4'b0101: r.res = (a < b) ? 1 : 0;
      4'b0111: r.res = (sa < sb) ? 1 : 0;
      4'b1000: r.res = a << sh;
      4'b1001: r.res = a >> sh;
      4'b1010: r.res = W'(sa >>> sh);
      4'b1100: begin
        if (MUL_EN) begin
          p     = 64'(a) * 64'(b);
          r.res = p[31:0];
          r.ovf = (p[63:32] != 0);
        end else begin
          r.ill = 1'b1;
        end
      end
      default: r.ill = 1'b1;
    endcase
    r.zero = (r.res == 0);
    return r;
  endfunction

  function automatic exp_t observed();
    return '{res: Result, ovf: Overflow, cy: CarryOut, zero: Zero, ill: Illegal};
  endfunction

  // Issue one op from an idle-ish pipe; returns cycles from accept edge to out_valid.
  task automatic send(input string name, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int lat);
    int n;
    @(negedge clk);
    ALUop = op; A = a; B = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  vec_t        vecs[$];
  logic [3:0]  b2b_op[4];
  logic [W-1:0] b2b_a[4], b2b_b[4];

  initial begin
    int   lat;
    exp_t e, held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; ALUop = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(observed()), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;

    // Directed vector table
    vecs.push_back('{"add_ovf",    ALU_ADD,  32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"add_carry",  ALU_ADD,  32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0}, 1});
    vecs.push_back('{"sub_eq",     ALU_SUB,  32'h00000005, 32'h00000005, '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}, 1});
    vecs.push_back('{"sub_borrow", ALU_SUB,  32'h00000000, 32'h00000001, '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0}, 1});
    vecs.push_back('{"sub_ovf",    ALU_SUB,  32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"slt_ovf",    ALU_SLT,  32'h80000000, 32'h7FFFFFFF, '{32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"sltu",       ALU_SLTU, 32'h80000000, 32'h7FFFFFFF, '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}, 1});
    vecs.push_back('{"sra",        ALU_SRA,  32'hF0000000, 32'h00000024, '{32'hFF000000, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"srl",        ALU_SRL,  32'hF0000000, 32'h00000004, '{32'h0F000000, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"sll",        ALU_SLL,  32'h00000001, 32'hFFFFFFFF, '{32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"and",        ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, '{32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"or",         ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, '{32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"xor",        ALU_XOR,  32'hA5A5A5A5, 32'hFFFF0000, '{32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"nor",        ALU_NOR,  32'h00000000, 32'h00000000, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}, 1});
    vecs.push_back('{"illegal_b",  4'b1011,  32'h12345678, 32'h9ABCDEF0, '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1}, 1});
`ifdef ALU_MUL_EN
    vecs.push_back('{"mul_ovf",    ALU_MUL,  32'h00010000, 32'h00010000, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}, 33});
    vecs.push_back('{"mul_small",  ALU_MUL,  32'h00001234, 32'h00000100, '{32'h00123400, 1'b0, 1'b0, 1'b0, 1'b0}, 33});
`else
    vecs.push_back('{"mul_illegal", ALU_MUL, 32'h00010000, 32'h00010000, '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1}, 1});
`endif
    foreach (vecs[i]) begin
      send(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check(vecs[i].name, 64'(observed()), 64'(vecs[i].exp));
    end

    // Back-to-back: four ops, one result per cycle
    b2b_op = '{ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLL};
    b2b_a  = '{32'h00000010, 32'hDEADBEEF, 32'h00000003, 32'h00000003};
    b2b_b  = '{32'h00000020, 32'hFFFFFFFF, 32'h00000007, 32'h00000004};
    @(negedge clk);
    ALUop = b2b_op[0]; A = b2b_a[0]; B = b2b_b[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("b2b_result_%0d", i), 64'(observed()),
            64'(model(b2b_op[i], b2b_a[i], b2b_b[i])));
      if (i < 3) begin
        ALUop = b2b_op[i+1]; A = b2b_a[i+1]; B = b2b_b[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end

    // Output stall: result held, no new op accepted while out_ready=0
    @(negedge clk);
    ALUop = ALU_ADD; A = 32'd1; B = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    held = model(ALU_ADD, 32'd1, 32'd2);
    check("stall_first", 64'(observed()), 64'(held));
    out_ready = 1'b0;
    ALUop = ALU_NOR; A = 32'h0000FFFF; B = 32'h00FF0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_in_ready_%0d", k), 64'(in_ready), 64'd0);
      check($sformatf("stall_valid_%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("stall_hold_%0d", k), 64'(observed()), 64'(held));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("stall_release", 64'(observed()), 64'(model(ALU_NOR, 32'h0000FFFF, 32'h00FF0000)));

    // Randomized ops with random output back-pressure
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      int           stall;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: a = {1'b1, 31'($urandom_range(0, 3))};
        1: b = a;
        default: ;
      endcase
      e = model(op, a, b);
      send("rand", op, a, b, lat);
      check("rand_latency", 64'(lat), (MUL_EN && op == 4'b1100) ? 64'd33 : 64'd1);
      check($sformatf("rand_op%h_%h_%h", op, a, b), 64'(observed()), 64'(e));
      stall = $urandom_range(0, 2);
      if (stall > 0) begin
        out_ready = 1'b0;
        repeat (stall) begin
          @(posedge clk);
          #1;
          check("rand_stall_hold", 64'(observed()), 64'(e));
        end
        out_ready = 1'b1;
      end
    end

`ifdef ALU_MUL_EN
    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    ALUop = ALU_MUL; A = 32'h00010000; B = 32'h00010000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mul_busy_in_ready", 64'(in_ready), 64'd0);
    check("mul_busy_out_valid", 64'(out_valid), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mul_abort_in_ready", 64'(in_ready), 64'd1);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("mul_abort_no_result", 64'(seen), 64'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
